// File: rtl/app_byte_buffer.sv
// app_byte_buffer
//
// Elastic byte buffer that sits between the usb_cdc bulk OUT application
// stream and the bulk IN application stream of the loopback top. Bytes are
// stored in a DEPTH-entry FIFO and held back (HOLD) until either
// FLUSH_THRESHOLD bytes have collected, the FIFO is full, or the stream has
// gone quiet for IDLE_TIMEOUT cycles. A burst is then released (DRAIN) until
// the FIFO runs empty. This lets the IN side form full-size packets.
// A stretched activity flag drives the board LED.
//
// Handshake semantics (both streams): a byte moves on a rising clk_i edge
// where valid and ready are both high. The producer keeps valid and data
// stable until that edge. ready may not depend on valid.
//
// Ports:
//   clk_i       single clock (usb_cdc application domain)
//   rst_i       synchronous, active-high reset
//   rx_data_i   byte from usb_cdc OUT stream
//   rx_valid_i  rx_data_i valid
//   rx_ready_o  buffer accepts a byte (low while full or in reset)
//   tx_data_o   FIFO head byte to usb_cdc IN stream
//   tx_valid_o  tx_data_o valid (only while draining a burst)
//   tx_ready_i  usb_cdc accepts byte
//   level_o     current byte count, 0..DEPTH
//   activity_o  high while traffic was seen recently

module app_byte_buffer #(
  parameter int DEPTH           = 64,
  parameter int FLUSH_THRESHOLD = 16,
  parameter int IDLE_TIMEOUT    = 1024,
  parameter int ACT_CYCLES      = 262144
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [7:0]               rx_data_i,
  input  logic                     rx_valid_i,
  output logic                     rx_ready_o,
  output logic [7:0]               tx_data_o,
  output logic                     tx_valid_o,
  input  logic                     tx_ready_i,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     activity_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int IW = $clog2(IDLE_TIMEOUT + 1);
  localparam int CW = $clog2(ACT_CYCLES + 1);

  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
  localparam logic [LW-1:0] THR_LVL  = LW'(FLUSH_THRESHOLD);
  localparam logic [LW-1:0] ONE_LVL  = LW'(1);
  localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_TIMEOUT);
  localparam logic [CW-1:0] ACT_LOAD = CW'(ACT_CYCLES - 1);

  typedef enum logic [0:0] {
    ST_HOLD  = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  // state is the FSM's observable state; bind checkers to it by name.
  state_t state;
  state_t state_next;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [IW-1:0] idle_cnt;
  logic [CW-1:0] act_cnt;

  logic push;
  logic pop;
  logic empty;
  logic full;

  assign empty = (level_o == '0);
  assign full  = (level_o == FULL_LVL);
  assign push  = rx_valid_i & rx_ready_o;
  assign pop   = tx_valid_o & tx_ready_i;

  // Combinational read of the FIFO head.
  assign tx_data_o = mem[rd_ptr];

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= ST_HOLD;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_HOLD: begin
        if ((level_o >= THR_LVL) || full || (!empty && (idle_cnt == IDLE_MAX))) begin
          state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Leave on the edge that removes the last byte, unless a new byte
        // arrives on the same edge and extends the burst.
        if (empty || (pop && !push && (level_o == ONE_LVL))) begin
          state_next = ST_HOLD;
        end
      end
      default: state_next = ST_HOLD;
    endcase
  end

  always_comb begin
    // Ready depends on full only; a same-cycle pop does not open a slot.
    rx_ready_o = !rst_i && !full;
    // level_o only falls through a pop, so valid/data stay stable until one.
    tx_valid_o = (state == ST_DRAIN) && !empty;
  end

  // ----------------------------------------------------------- datapath
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= rx_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_o <= '0;
    end else begin
      // DEPTH is a power of two, so pointers wrap naturally.
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        level_o <= level_o + ONE_LVL;
      end else if (pop && !push) begin
        level_o <= level_o - ONE_LVL;
      end
    end
  end

  // Idle counter: measures quiet time while bytes wait in HOLD.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idle_cnt <= '0;
    end else if (push || empty) begin
      idle_cnt <= '0;
    end else if ((state == ST_HOLD) && (idle_cnt != IDLE_MAX)) begin
      idle_cnt <= idle_cnt + IW'(1);
    end
  end

  // Activity stretcher for the LED.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      act_cnt <= '0;
    end else if (push || pop) begin
      act_cnt <= ACT_LOAD;
    end else if (act_cnt != '0) begin
      act_cnt <= act_cnt - CW'(1);
    end
  end

  assign activity_o = (act_cnt != '0) | push | pop;

endmodule

// File: tb/tb_app_byte_buffer.sv
// Testbench for app_byte_buffer: directed scenarios, a queue-based
// behavioural model checked every cycle, and a byte scoreboard.

module tb_app_byte_buffer;

  localparam int DEPTH = 64;
  localparam int THR   = 16;
  localparam int TO    = 8;
  localparam int ACT   = 20;
  localparam int LW    = $clog2(DEPTH) + 1;

  // ------------------------------------------------ clock / reset block
  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic [7:0]    rx_data_i = 8'h00;
  logic          rx_valid_i = 1'b0;
  logic          tx_ready_i = 1'b0;
  logic          rx_ready_o;
  logic [7:0]    tx_data_o;
  logic          tx_valid_o;
  logic [LW-1:0] level_o;
  logic          activity_o;

  always #5 clk = ~clk;

  app_byte_buffer #(
    .DEPTH(DEPTH),
    .FLUSH_THRESHOLD(THR),
    .IDLE_TIMEOUT(TO),
    .ACT_CYCLES(ACT)
  ) dut (
    .clk_i(clk),
    .rst_i(rst_i),
    .rx_data_i(rx_data_i),
    .rx_valid_i(rx_valid_i),
    .rx_ready_o(rx_ready_o),
    .tx_data_o(tx_data_o),
    .tx_valid_o(tx_valid_o),
    .tx_ready_i(tx_ready_i),
    .level_o(level_o),
    .activity_o(activity_o)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic check_eq(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act_v, exp_v, cyc);
    end
  endtask

  // ------------------------------------------------ behavioural model
  // FIFO contents as a queue, a draining flag, quiet-time and LED timers.
  logic [7:0] m_q[$];
  bit         m_drain = 1'b0;
  int         m_idle = 0;
  int         m_act = 0;
  bit         model_on = 1'b0;

  function automatic bit m_ready();
    return !rst_i && (m_q.size() < DEPTH);
  endfunction

  function automatic bit m_valid();
    return m_drain && (m_q.size() != 0);
  endfunction

  initial begin : model_proc
    int lvl;
    bit mp, mo, nd;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst_i) begin
        m_q.delete();
        m_drain  = 1'b0;
        m_idle   = 0;
        m_act    = 0;
        model_on = 1'b1;
      end else if (model_on) begin
        lvl = m_q.size();
        mp  = rx_valid_i && m_ready();
        mo  = m_valid() && tx_ready_i;
        if (!m_drain) nd = (lvl >= THR) || (lvl == DEPTH) || (lvl > 0 && m_idle == TO);
        else          nd = !((lvl == 0) || (lvl == 1 && mo && !mp));
        if (mp || lvl == 0)            m_idle = 0;
        else if (!m_drain && m_idle < TO) m_idle++;
        if (mp || mo)      m_act = ACT - 1;
        else if (m_act > 0) m_act--;
        if (mo) void'(m_q.pop_front());
        if (mp) m_q.push_back(rx_data_i);
        m_drain = nd;
      end
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  initial begin : compare_proc
    bit mp_c, mo_c;
    forever begin
      @(negedge clk);
      if (model_on) begin
        mp_c = rx_valid_i && m_ready();
        mo_c = m_valid() && tx_ready_i;
        check_eq("rx_ready", {31'd0, rx_ready_o}, {31'd0, m_ready()});
        check_eq("tx_valid", {31'd0, tx_valid_o}, {31'd0, m_valid()});
        check_eq("level", 32'(level_o), 32'(m_q.size()));
        check_eq("activity", {31'd0, activity_o}, {31'd0, (m_act != 0) || mp_c || mo_c});
        if (m_valid()) check_eq("tx_data", 32'(tx_data_o), 32'(m_q[0]));
      end
    end
  end

  // ------------------------------------------------ scoreboard
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  initial begin : sb_proc
    forever begin
      @(negedge clk);
      if (model_on && !rst_i && tx_valid_o && tx_ready_i) begin
        got_q.push_back(tx_data_o);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: got byte %0h expected none", tx_data_o);
        end else begin
          check_eq("sb_data", 32'(tx_data_o), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  // ------------------------------------------------ driver tasks
  // Called just after a rising edge; returns just after the next one.
  task automatic drive_cycle(input logic v, input logic [7:0] d, input logic r, output logic acc);
    rx_valid_i = v;
    rx_data_i  = d;
    tx_ready_i = r;
    @(negedge clk);
    acc = v & rx_ready_o;
    @(posedge clk);
    #1;
    if (acc) exp_q.push_back(d);
  endtask

  task automatic wait_empty(input int budget);
    bit done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      @(negedge clk);
      if (level_o == '0 && !tx_valid_o) done = 1'b1;
      @(posedge clk);
      #1;
    end
    check_eq("drain_done", {31'd0, done}, 32'd1);
  endtask

  task automatic check_got(input string name, input logic [7:0] first, input int n);
    check_eq({name, "_count"}, 32'(got_q.size()), 32'(n));
    for (int i = 0; i < n && i < got_q.size(); i++) begin
      check_eq(name, 32'(got_q[i]), 32'(8'(first + 8'(i))));
    end
  endtask

  // ------------------------------------------------ watchdog
  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // ------------------------------------------------ directed stimulus
  initial begin : main_proc
    logic acc;
    int k, e, n;
    bit done;

    // Reset held with rx_valid high.
    rst_i      = 1'b1;
    rx_valid_i = 1'b1;
    rx_data_i  = 8'h55;
    tx_ready_i = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      check_eq("rst_rx_ready", {31'd0, rx_ready_o}, 32'd0);
      check_eq("rst_tx_valid", {31'd0, tx_valid_o}, 32'd0);
      check_eq("rst_level", 32'(level_o), 32'd0);
      check_eq("rst_activity", {31'd0, activity_o}, 32'd0);
    end
    @(posedge clk);
    #1;
    rst_i      = 1'b0;
    rx_valid_i = 1'b0;
    @(negedge clk);
    check_eq("rel_rx_ready", {31'd0, rx_ready_o}, 32'd1);
    @(posedge clk);
    #1;

    // Threshold burst: 0x01..0x10.
    got_q.delete();
    for (int i = 0; i < 16; i++) begin
      drive_cycle(1'b1, 8'(i + 1), 1'b1, acc);
      check_eq("thr_accept", {31'd0, acc}, 32'd1);
    end
    rx_valid_i = 1'b0;
    @(negedge clk);
    check_eq("thr_level16", 32'(level_o), 32'd16);
    check_eq("thr_hold_valid", {31'd0, tx_valid_o}, 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check_eq("thr_first_valid", {31'd0, tx_valid_o}, 32'd1);
    check_eq("thr_first_data", 32'(tx_data_o), 32'h01);
    @(posedge clk);
    #1;
    wait_empty(100);
    check_got("thr_out", 8'h01, 16);

    // Idle flush: 7 bytes, then silence.
    got_q.delete();
    for (int i = 0; i < 7; i++) drive_cycle(1'b1, 8'(i + 1), 1'b1, acc);
    e = cyc;
    rx_valid_i = 1'b0;
    done = 1'b0;
    for (int c = 0; c < 30 && !done; c++) begin
      @(negedge clk);
      if (tx_valid_o) done = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    check_eq("idle_flush_seen", {31'd0, done}, 32'd1);
    if (done) begin
      check_eq("idle_flush_delay", 32'(cyc - e), 32'd9);
      @(posedge clk);
      #1;
    end
    wait_empty(100);
    check_got("idle_out", 8'h01, 7);

    // Backpressure until full, then release.
    got_q.delete();
    k = 0;
    for (int c = 0; c < 75; c++) begin
      drive_cycle(k < 70, 8'(k), 1'b0, acc);
      if (acc) k++;
    end
    check_eq("full_accepted", 32'(k), 32'd64);
    @(negedge clk);
    check_eq("full_rx_ready", {31'd0, rx_ready_o}, 32'd0);
    check_eq("full_level", 32'(level_o), 32'd64);
    check_eq("full_tx_valid", {31'd0, tx_valid_o}, 32'd1);
    check_eq("full_tx_data", 32'(tx_data_o), 32'h00);
    @(posedge clk);
    #1;
    for (int c = 0; c < 300 && k < 70; c++) begin
      drive_cycle(1'b1, 8'(k), 1'b1, acc);
      if (acc) k++;
    end
    rx_valid_i = 1'b0;
    wait_empty(200);
    check_eq("full_total", 32'(k), 32'd70);
    check_got("full_out", 8'h00, 70);

    // Simultaneous push/pop at level 5, then a random run across the wrap.
    got_q.delete();
    for (int i = 0; i < 16; i++) drive_cycle(1'b1, 8'(8'h80 + 8'(i)), 1'b0, acc);
    drive_cycle(1'b0, 8'h00, 1'b0, acc);
    for (int i = 0; i < 11; i++) drive_cycle(1'b0, 8'h00, 1'b1, acc);
    tx_ready_i = 1'b0;
    @(negedge clk);
    check_eq("pp_level5", 32'(level_o), 32'd5);
    check_eq("pp_valid", {31'd0, tx_valid_o}, 32'd1);
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) drive_cycle(1'b1, 8'(8'h90 + 8'(i)), 1'b1, acc);
    rx_valid_i = 1'b0;
    tx_ready_i = 1'b0;
    @(negedge clk);
    check_eq("pp_level_held", 32'(level_o), 32'd5);
    @(posedge clk);
    #1;
    n = 0;
    for (int c = 0; c < 4000 && n < 200; c++) begin
      drive_cycle(1'($urandom_range(0, 1)), 8'(n), 1'($urandom_range(0, 1)), acc);
      if (acc) n++;
    end
    rx_valid_i = 1'b0;
    tx_ready_i = 1'b1;
    wait_empty(300);
    check_eq("rand_pushed", 32'(n), 32'd200);
    check_eq("rand_popped", 32'(got_q.size()), 32'd220);
    check_eq("rand_sb_left", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of a burst at level 10.
    got_q.delete();
    for (int i = 0; i < 16; i++) drive_cycle(1'b1, 8'(8'hA0 + 8'(i)), 1'b0, acc);
    drive_cycle(1'b0, 8'h00, 1'b0, acc);
    for (int i = 0; i < 6; i++) drive_cycle(1'b0, 8'h00, 1'b1, acc);
    tx_ready_i = 1'b0;
    @(negedge clk);
    check_eq("mid_level10", 32'(level_o), 32'd10);
    check_eq("mid_valid", {31'd0, tx_valid_o}, 32'd1);
    @(posedge clk);
    #1;
    rst_i = 1'b1;
    drive_cycle(1'b1, 8'hEE, 1'b0, acc);
    check_eq("mid_rst_no_accept", {31'd0, acc}, 32'd0);
    rst_i = 1'b0;
    rx_valid_i = 1'b0;
    exp_q.delete();
    got_q.delete();
    @(negedge clk);
    check_eq("mid_rst_level", 32'(level_o), 32'd0);
    check_eq("mid_rst_valid", {31'd0, tx_valid_o}, 32'd0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) drive_cycle(1'b1, 8'(8'h30 + 8'(i)), 1'b1, acc);
    rx_valid_i = 1'b0;
    wait_empty(100);
    check_got("post_rst_out", 8'h30, 16);

    // Activity decays once traffic stops.
    tx_ready_i = 1'b0;
    repeat (ACT + 5) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    check_eq("act_decay", {31'd0, activity_o}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
